capture_sequencer: RTL and testbench
====================================

Name: capture_sequencer

Overview:
- Sequences a logic-capture run from register-level commands.
- Start/stop come in as single-cycle pulses decoded from the status/control register write; divisor and channel mask come from the sample-rate-divisor and channel-select registers.
- Generates the per-sample strobe for the sampling datapath, counts samples, and detects FIFO overflow.
- Exports a status byte for register readback.
- Sits in the normal clock domain between the register decode and the sample/FIFO path.

Parameters:
- DIV_W, 8, width of the sample-rate divisor.
- CH_W, 16, number of input channels (mask width).
- CNT_W, 32, width of the sample counter and sample limit.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle start command pulse.
- stop  input  1  one-cycle stop command pulse.
- divisor  input  DIV_W  sample period minus one, in clk cycles.
- channel_mask  input  CH_W  channels to capture.
- sample_limit  input  CNT_W  samples per run; 0 means unlimited.
- fifo_full  input  1  downstream FIFO cannot accept a sample this cycle.
- sample_en  output  1  one-cycle strobe: take a sample now.
- active_mask  output  CH_W  channel mask latched at start.
- sample_count  output  CNT_W  samples issued in the current/last run.
- running  output  1  high while in RUN.
- status  output  8  {4'b0, cfg_err, done, overflow, running}.

Behaviour:
- Reset values:
  - state IDLE.
  - sample_en 0, running 0, overflow 0, done 0, cfg_err 0.
  - active_mask 0, sample_count 0, divide counter 0.
- States: IDLE, RUN, HALT. HALT covers overflow or limit reached; it holds the flags.
- Start acceptance (IDLE or HALT):
  - start with channel_mask != 0 and stop low is accepted.
  - On acceptance: latch active_mask and divisor into internal copies, load divide counter with divisor, clear sample_count/overflow/done/cfg_err, go to RUN next cycle.
  - start with channel_mask == 0 is rejected: cfg_err <= 1, state unchanged.
  - start while in RUN is ignored.
- Divider in RUN:
  - If counter == 0: sample strobe condition; reload counter with latched divisor.
  - Otherwise: decrement.
  - Accepted start at cycle T gives the first strobe condition at T+1+divisor, then every divisor+1 cycles.
  - divisor 0 gives a strobe every cycle from T+1.
  - Register changes to divisor or channel_mask mid-run have no effect.
- Strobe and FIFO interaction:
  - When the strobe condition holds and fifo_full is 0: sample_en = 1 (registered output, same cycle the condition is evaluated) and sample_count increments.
  - When the strobe condition holds and fifo_full is 1: no sample_en, overflow <= 1, go to HALT.
  - fifo_full outside a strobe cycle is ignored.
- Sample limit:
  - If sample_limit != 0 and the incremented count equals sample_limit: done <= 1, go to HALT after that strobe.
  - sample_limit is latched at start.
  - Unlimited runs saturate sample_count at all-ones and keep running.
- Stop:
  - stop in RUN: go to IDLE next cycle, no further sample_en; sample_count and the flags are kept.
  - stop in HALT: go to IDLE and keep the flags.
  - stop in IDLE: no effect.
- Simultaneous events: stop and start in the same cycle means stop wins and start is dropped. Stop in a strobe cycle suppresses that strobe.
- Output relations: running == (state == RUN). status bits are registered state, no combinational path from inputs.
- Reset mid-run: all outputs return to reset values the next cycle and no sample_en is emitted.

Decomposition:
- Shared package capture_pkg holds:
  - state encoding: IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2.
  - status bit indices: RUNNING = 0, OVERFLOW = 1, DONE = 2, CFG_ERR = 3.
  - register address constants for status/control, channel select low/high, sample-rate divisor.
- One sub-module, rate_divider: load/enable/reload down-counter producing the strobe condition, parameterised by DIV_W.

Test Plan:
- divisor=3, mask=16'h0001, limit=0, start at T: sample_en at T+4, T+8, T+12; running=1; status=8'h01.
- divisor=0, limit=5, mask=16'hFFFF: five consecutive sample_en from T+1; done=1, state HALT, status=8'h04, sample_count=5.
- divisor=1, fifo_full high on the 3rd strobe cycle: only 2 sample_en; overflow=1, status=8'h02; the next accepted start clears overflow.
- start with mask=0: no RUN, status=8'h08; start with mask=16'h00F0 then gives status=8'h01 and active_mask=16'h00F0.
- start and stop in the same cycle from IDLE: stays IDLE. stop in a strobe cycle during RUN: no sample_en that cycle, IDLE next cycle.
- rst asserted mid-run (divisor=2): next cycle all outputs zero, no sample_en; divisor changed mid-run: period unchanged until the next start.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared encodings for the capture sequencer: FSM states, status-bit layout
// and the register addresses that feed its command inputs.
package capture_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int unsigned STATUS_W = 8;
  localparam int unsigned RUNNING  = 0;
  localparam int unsigned OVERFLOW = 1;
  localparam int unsigned DONE     = 2;
  localparam int unsigned CFG_ERR  = 3;

  localparam logic [7:0] ADDR_STATUS_CTRL = 8'h00;
  localparam logic [7:0] ADDR_CHSEL_LO    = 8'h04;
  localparam logic [7:0] ADDR_CHSEL_HI    = 8'h08;
  localparam logic [7:0] ADDR_DIVISOR     = 8'h0C;

endpackage

// File: rtl/rate_divider.sv
// Reloading down-counter: flags a tick whenever it sits at zero while enabled,
// reloading from the period captured at load time.
module rate_divider #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_tick_c
);

  logic [DIV_W-1:0] r_count;
  logic [DIV_W-1:0] r_period;

  assign o_tick_c = i_en && (r_count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_period <= '0;
    end else if (i_load) begin
      r_count  <= i_load_val;
      r_period <= i_load_val;
    end else if (i_en) begin
      r_count <= (r_count == '0) ? r_period : r_count - DIV_W'(1);
    end
  end

endmodule

// File: rtl/capture_sequencer.sv
// Capture-run sequencer: accepts start/stop commands, paces sample strobes,
// counts samples, and stops on FIFO overflow or sample limit.
module capture_sequencer
  import capture_pkg::*;
#(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned CH_W  = 16,
  parameter int unsigned CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [DIV_W-1:0]    divisor,
  input  logic [CH_W-1:0]     channel_mask,
  input  logic [CNT_W-1:0]    sample_limit,
  input  logic                fifo_full,
  output logic                sample_en,
  output logic [CH_W-1:0]     active_mask,
  output logic [CNT_W-1:0]    sample_count,
  output logic                running,
  output logic [STATUS_W-1:0] status
);

  state_t           r_state;
  logic             r_sample_en;
  logic             r_overflow;
  logic             r_done;
  logic             r_cfg_err;
  logic [CH_W-1:0]  r_active_mask;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_limit;

  logic                w_run_c;
  logic                w_accept_c;
  logic                w_tick_c;
  logic [CNT_W-1:0]    w_count_inc;
  logic [STATUS_W-1:0] w_status;

  assign w_run_c     = (r_state == RUN);
  assign w_accept_c  = !w_run_c && start && !stop && (channel_mask != '0);
  assign w_count_inc = r_count + CNT_W'(1);

  rate_divider #(
    .DIV_W (DIV_W)
  ) u_rate_divider (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept_c),
    .i_load_val (divisor),
    .i_en       (w_run_c),
    .o_tick_c   (w_tick_c)
  );

  // Stop always dominates; a strobe is either issued or turned into an overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_sample_en   <= 1'b0;
      r_overflow    <= 1'b0;
      r_done        <= 1'b0;
      r_cfg_err     <= 1'b0;
      r_active_mask <= '0;
      r_count       <= '0;
      r_limit       <= '0;
    end else begin
      r_sample_en <= 1'b0;
      case (r_state)
        IDLE, HALT: begin
          if (stop) begin
            r_state <= IDLE;
          end else if (w_accept_c) begin
            r_state       <= RUN;
            r_active_mask <= channel_mask;
            r_limit       <= sample_limit;
            r_count       <= '0;
            r_overflow    <= 1'b0;
            r_done        <= 1'b0;
            r_cfg_err     <= 1'b0;
          end else if (start) begin
            r_cfg_err <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            r_state <= IDLE;
          end else if (w_tick_c) begin
            if (fifo_full) begin
              r_overflow <= 1'b1;
              r_state    <= HALT;
            end else begin
              r_sample_en <= 1'b1;
              if (r_count != '1) r_count <= w_count_inc;
              if ((r_limit != '0) && (w_count_inc == r_limit)) begin
                r_done  <= 1'b1;
                r_state <= HALT;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_status           = '0;
    w_status[RUNNING]  = w_run_c;
    w_status[OVERFLOW] = r_overflow;
    w_status[DONE]     = r_done;
    w_status[CFG_ERR]  = r_cfg_err;
  end

  assign sample_en    = r_sample_en;
  assign active_mask  = r_active_mask;
  assign sample_count = r_count;
  assign running      = w_run_c;
  assign status       = w_status;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: per-cycle vector table plus
// hand-written reset-mid-run and divisor-change sequences.
module tb_capture_sequencer;

  localparam int unsigned DIV_W = 8;
  localparam int unsigned CH_W  = 16;
  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             stop;
  logic [DIV_W-1:0] divisor;
  logic [CH_W-1:0]  channel_mask;
  logic [CNT_W-1:0] sample_limit;
  logic             fifo_full;
  logic             sample_en;
  logic [CH_W-1:0]  active_mask;
  logic [CNT_W-1:0] sample_count;
  logic             running;
  logic [7:0]       status;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  capture_sequencer #(
    .DIV_W (DIV_W),
    .CH_W  (CH_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .divisor      (divisor),
    .channel_mask (channel_mask),
    .sample_limit (sample_limit),
    .fifo_full    (fifo_full),
    .sample_en    (sample_en),
    .active_mask  (active_mask),
    .sample_count (sample_count),
    .running      (running),
    .status       (status)
  );

  typedef struct {
    logic        rst;
    logic        start;
    logic        stop;
    logic        ff;
    logic [7:0]  div;
    logic [15:0] mask;
    logic [31:0] lim;
    logic        exp_se;
    logic        exp_run;
    logic [7:0]  exp_st;
    logic [31:0] exp_cnt;
    logic [15:0] exp_amask;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic s, input logic p, input logic f,
                              input logic [7:0] d, input logic [15:0] m, input logic [31:0] l,
                              input logic se, input logic rn, input logic [7:0] st,
                              input logic [31:0] cnt, input logic [15:0] am);
    vec_t v;
    v.rst = r; v.start = s; v.stop = p; v.ff = f;
    v.div = d; v.mask = m; v.lim = l;
    v.exp_se = se; v.exp_run = rn; v.exp_st = st; v.exp_cnt = cnt; v.exp_amask = am;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic se, input logic rn, input logic [7:0] st,
                           input logic [31:0] cnt, input logic [15:0] am);
    chk({tag, " sample_en"}, 32'(sample_en), 32'(se));
    chk({tag, " running"}, 32'(running), 32'(rn));
    chk({tag, " status"}, 32'(status), 32'(st));
    chk({tag, " sample_count"}, sample_count, cnt);
    chk({tag, " active_mask"}, 32'(active_mask), 32'(am));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; fifo_full = 1'b0;
    divisor = '0; channel_mask = '0; sample_limit = '0;

    // reset
    add(1,0,0,0, 8'd3,16'h0001,0, 0,0,8'h00,0,16'h0000);
    // divisor 3, unlimited: strobes every 4th edge
    add(0,1,0,0, 8'd3,16'h0001,0, 0,1,8'h01,0,16'h0001);
    for (int k = 1; k <= 3; k++) begin
      for (int j = 0; j < 3; j++) add(0,0,0,0, 8'd3,16'h0001,0, 0,1,8'h01,32'(k-1),16'h0001);
      add(0,0,0,0, 8'd3,16'h0001,0, 1,1,8'h01,32'(k),16'h0001);
    end
    add(0,0,1,0, 8'd3,16'h0001,0, 0,0,8'h00,3,16'h0001);
    // divisor 0, limit 5
    add(0,1,0,0, 8'd0,16'hFFFF,5, 0,1,8'h01,0,16'hFFFF);
    for (int k = 1; k <= 5; k++)
      add(0,0,0,0, 8'd0,16'hFFFF,5, 1,(k < 5),(k < 5) ? 8'h01 : 8'h04,32'(k),16'hFFFF);
    add(0,0,0,0, 8'd0,16'hFFFF,5, 0,0,8'h04,5,16'hFFFF);
    add(0,0,1,0, 8'd0,16'hFFFF,5, 0,0,8'h04,5,16'hFFFF);
    // divisor 1, FIFO full on the 3rd strobe (and off-strobe, ignored)
    add(0,1,0,0, 8'd1,16'h0001,0, 0,1,8'h01,0,16'h0001);
    add(0,0,0,1, 8'd1,16'h0001,0, 0,1,8'h01,0,16'h0001);
    add(0,0,0,0, 8'd1,16'h0001,0, 1,1,8'h01,1,16'h0001);
    add(0,0,0,1, 8'd1,16'h0001,0, 0,1,8'h01,1,16'h0001);
    add(0,0,0,0, 8'd1,16'h0001,0, 1,1,8'h01,2,16'h0001);
    add(0,0,0,0, 8'd1,16'h0001,0, 0,1,8'h01,2,16'h0001);
    add(0,0,0,1, 8'd1,16'h0001,0, 0,0,8'h02,2,16'h0001);
    add(0,0,0,0, 8'd1,16'h0001,0, 0,0,8'h02,2,16'h0001);
    // restart from HALT clears overflow; start in RUN and new divisor ignored
    add(0,1,0,0, 8'd2,16'h000F,0, 0,1,8'h01,0,16'h000F);
    add(0,1,0,0, 8'd0,16'h00FF,0, 0,1,8'h01,0,16'h000F);
    add(0,0,0,0, 8'd0,16'h00FF,0, 0,1,8'h01,0,16'h000F);
    add(0,0,0,0, 8'd0,16'h00FF,0, 1,1,8'h01,1,16'h000F);
    add(0,0,0,0, 8'd0,16'h00FF,0, 0,1,8'h01,1,16'h000F);
    add(0,0,0,0, 8'd0,16'h00FF,0, 0,1,8'h01,1,16'h000F);
    // stop on a strobe edge suppresses it
    add(0,0,1,0, 8'd0,16'h00FF,0, 0,0,8'h00,1,16'h000F);
    // zero mask rejected, then valid start
    add(0,1,0,0, 8'd3,16'h0000,0, 0,0,8'h08,1,16'h000F);
    add(0,1,0,0, 8'd3,16'h00F0,0, 0,1,8'h01,0,16'h00F0);
    add(0,0,1,0, 8'd3,16'h00F0,0, 0,0,8'h00,0,16'h00F0);
    // start and stop together from IDLE
    add(0,1,1,0, 8'd3,16'h0001,0, 0,0,8'h00,0,16'h00F0);
    add(0,0,0,0, 8'd3,16'h0001,0, 0,0,8'h00,0,16'h00F0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; start = vecs[i].start; stop = vecs[i].stop;
      fifo_full = vecs[i].ff; divisor = vecs[i].div;
      channel_mask = vecs[i].mask; sample_limit = 32'(vecs[i].lim);
      step();
      check_all($sformatf("v%0d", i), vecs[i].exp_se, vecs[i].exp_run,
                vecs[i].exp_st, vecs[i].exp_cnt, vecs[i].exp_amask);
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0; fifo_full = 1'b0;

    // reset on what would be the first strobe edge of a divisor-2 run
    divisor = 8'd2; channel_mask = 16'h0003; sample_limit = '0; start = 1'b1;
    step();
    start = 1'b0;
    check_all("rst_run", 1'b0, 1'b1, 8'h01, 0, 16'h0003);
    step();
    step();
    rst = 1'b1;
    step();
    check_all("rst_hit", 1'b0, 1'b0, 8'h00, 0, 16'h0000);
    rst = 1'b0;
    step();
    check_all("rst_after", 1'b0, 1'b0, 8'h00, 0, 16'h0000);

    // register changes mid-run leave period and mask untouched
    divisor = 8'd2; channel_mask = 16'h0005; start = 1'b1;
    step();
    start = 1'b0; divisor = 8'd7; channel_mask = 16'h0000;
    for (int k = 1; k <= 9; k++) begin
      step();
      check_all($sformatf("midchg%0d", k), (k % 3) == 0, 1'b1, 8'h01, 32'(k / 3), 16'h0005);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("midchg_stop running", 32'(running), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
